// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared sizes and FSM state type for the branch predictor table controller
package bpu_pkg;

  localparam int BPU_IDX_W   = 8;
  localparam int BPU_ENTRY_W = 39;
  localparam int BPU_DEPTH   = 2 ** BPU_IDX_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_e;

endpackage

// File: rtl/bpu_wbuf.sv
// rtl/bpu_wbuf.sv - one-entry update write buffer with a saturating 2-bit age counter
module bpu_wbuf
  import bpu_pkg::*;
#(
  parameter int IDX_W   = BPU_IDX_W,
  parameter int ENTRY_W = BPU_ENTRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic               drain,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [ENTRY_W-1:0] load_data,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [ENTRY_W-1:0] data,
  output logic [1:0]         age
);

  // A load wins over a drain in the same cycle: the old entry leaves, the new one enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      idx   <= '0;
      data  <= '0;
      age   <= 2'd0;
    end else if (clear) begin
      valid <= 1'b0;
      age   <= 2'd0;
    end else if (load) begin
      valid <= 1'b1;
      idx   <= load_idx;
      data  <= load_data;
      age   <= 2'd0;
    end else if (drain) begin
      valid <= 1'b0;
      age   <= 2'd0;
    end else if (valid && age != 2'd3) begin
      age <= age + 2'd1;
    end
  end

endmodule

// File: rtl/bpu_table_ctrl.sv
// rtl/bpu_table_ctrl.sv - BPU table controller: RAM init/flush, lookups, buffered updates
// Optional build macro BPU_TABLE_BYPASS_EN forwards buffered data to matching lookups.
module bpu_table_ctrl
  import bpu_pkg::*;
#(
  parameter int IDX_W   = BPU_IDX_W,
  parameter int ENTRY_W = BPU_ENTRY_W,
  parameter int DEPTH   = BPU_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [IDX_W-1:0]   lk_idx,
  output logic               rsp_valid,
  output logic [ENTRY_W-1:0] rsp_data,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [IDX_W-1:0]   up_idx,
  input  logic [ENTRY_W-1:0] up_data,
  output logic               ram_we,
  output logic [IDX_W-1:0]   ram_addr,
  output logic [ENTRY_W-1:0] ram_din,
  input  logic [ENTRY_W-1:0] ram_dout,
  output logic               init_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  bpu_state_e         state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic               run;
  logic               buf_valid;
  logic [IDX_W-1:0]   buf_idx;
  logic [ENTRY_W-1:0] buf_data;
  logic [1:0]         buf_age;
  logic               idx_hit, byp_hit, lk_block;
  logic               lk_fire, up_fire, drain;
  logic               rsp_valid_q, byp_q;
  logic [ENTRY_W-1:0] byp_data_q;

  assign run     = (state == RUN);
  assign idx_hit = lk_valid && buf_valid && (lk_idx == buf_idx);

`ifdef BPU_TABLE_BYPASS_EN
  assign byp_hit  = idx_hit;
  assign lk_block = 1'b0;
`else
  assign byp_hit  = 1'b0;
  assign lk_block = idx_hit;
`endif

  // A lookup owns the single RAM port; an aged-out buffer steals it by dropping lk_ready.
  assign lk_ready  = run && (buf_age != 2'd3) && !lk_block;
  assign lk_fire   = lk_valid && lk_ready;
  assign drain     = run && buf_valid && !lk_fire;
  assign up_ready  = run && (!buf_valid || drain);
  assign up_fire   = up_valid && up_ready;
  assign init_done = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && !flush && cnt != LAST_IDX) cnt <= cnt + 1'b1;
      else                                            cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = cnt;
    ram_din   = '0;
    case (state)
      INIT: begin
        ram_we = 1'b1;
        if (!flush && cnt == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        if (lk_fire) begin
          ram_addr = lk_idx;
        end else if (buf_valid) begin
          ram_we   = 1'b1;
          ram_addr = buf_idx;
          ram_din  = buf_data;
        end
        if (flush) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  bpu_wbuf #(
    .IDX_W   (IDX_W),
    .ENTRY_W (ENTRY_W)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (up_fire),
    .drain     (drain),
    .load_idx  (up_idx),
    .load_data (up_data),
    .valid     (buf_valid),
    .idx       (buf_idx),
    .data      (buf_data),
    .age       (buf_age)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      rsp_valid_q <= lk_fire;
      byp_q       <= lk_fire && byp_hit;
      if (lk_fire && byp_hit) byp_data_q <= buf_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = !rsp_valid_q ? '0 : (byp_q ? byp_data_q : ram_dout);

endmodule

// File: tb/tb_bpu_table_ctrl.sv
// tb/tb_bpu_table_ctrl.sv - self-checking bench for bpu_table_ctrl with an external RAM model
module tb_bpu_table_ctrl;

  localparam int IDX_W   = 8;
  localparam int ENTRY_W = 39;
  localparam int DEPTH   = 256;
`ifdef BPU_TABLE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               lk_valid;
  logic               lk_ready;
  logic [IDX_W-1:0]   lk_idx;
  logic               rsp_valid;
  logic [ENTRY_W-1:0] rsp_data;
  logic               up_valid;
  logic               up_ready;
  logic [IDX_W-1:0]   up_idx;
  logic [ENTRY_W-1:0] up_data;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [ENTRY_W-1:0] ram_din;
  logic [ENTRY_W-1:0] ram_dout;
  logic               init_done;

  always #5 clk = ~clk;

  logic [ENTRY_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  bpu_table_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .lk_valid  (lk_valid),
    .lk_ready  (lk_ready),
    .lk_idx    (lk_idx),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_idx    (up_idx),
    .up_data   (up_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  int n_chk;
  int n_fail;

  // Reference state: architectural table contents plus the visible handshake timing.
  logic [ENTRY_W-1:0] shadow [DEPTH];
  bit                 m_run;
  int                 m_cnt;
  bit                 m_bv;
  logic [IDX_W-1:0]   m_bidx;
  logic [ENTRY_W-1:0] m_bdata;
  int                 m_held;
  bit                 m_pend;
  logic [ENTRY_W-1:0] m_exp;

  logic               s_lk_ready, s_ram_we, s_rsp_valid;
  logic [ENTRY_W-1:0] s_rsp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_bv   = 1'b0;
    m_held = 0;
    m_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data,  0);
    chk({tag, "_lk_ready"},  lk_ready,  0);
    chk({tag, "_up_ready"},  up_ready,  0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_ram_we"},    ram_we,    1);
    chk({tag, "_ram_addr"},  ram_addr,  0);
    chk({tag, "_ram_din"},   ram_din,   0);
  endtask

  task automatic idle();
    lk_valid = 1'b0;
    up_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // One clock: sample at the falling edge, check against the model, advance the model.
  task automatic cycle();
    bit match, lkr, lk_acc, drn, upr, up_acc;
    @(negedge clk);
    s_lk_ready  = lk_ready;
    s_ram_we    = ram_we;
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    chk("rsp_valid", rsp_valid, m_pend);
    if (m_pend) chk("rsp_data", rsp_data, m_exp);
    if (!m_run) begin
      chk("init_ram_we", ram_we, 1);
      chk("init_ram_addr", ram_addr, m_cnt);
      chk("init_ram_din", ram_din, 0);
      chk("init_lk_ready", lk_ready, 0);
      chk("init_up_ready", up_ready, 0);
      chk("init_done_low", init_done, 0);
      m_pend = 1'b0;
      if (flush) m_cnt = 0;
      else if (m_cnt == DEPTH - 1) begin m_run = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else begin
      chk("run_init_done", init_done, 1);
      match  = lk_valid && m_bv && (lk_idx == m_bidx);
      lkr    = !(m_bv && m_held >= 3) && !(!BYP && match);
      lk_acc = lk_valid && lkr;
      drn    = m_bv && !lk_acc;
      upr    = !m_bv || drn;
      up_acc = up_valid && upr;
      chk("lk_ready", lk_ready, lkr);
      chk("up_ready", up_ready, upr);
      if (lk_acc) begin
        chk("rd_ram_we", ram_we, 0);
        chk("rd_ram_addr", ram_addr, lk_idx);
      end else if (m_bv) begin
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, m_bidx);
        chk("wr_ram_din", ram_din, m_bdata);
      end else begin
        chk("idle_ram_we", ram_we, 0);
      end
      m_pend = lk_acc;
      m_exp  = shadow[lk_idx];
      if (up_acc) shadow[up_idx] = up_data;
      if (flush) begin
        m_run  = 1'b0;
        m_cnt  = 0;
        m_bv   = 1'b0;
        m_held = 0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      end else if (up_acc) begin
        m_bv    = 1'b1;
        m_bidx  = up_idx;
        m_bdata = up_data;
        m_held  = 0;
      end else if (drn) begin
        m_bv = 1'b0;
      end else if (m_bv) begin
        m_held++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lookup_until(input logic [IDX_W-1:0] idx, output int n);
    bit ok;
    ok       = 1'b0;
    n        = 0;
    lk_valid = 1'b1;
    lk_idx   = idx;
    for (int i = 0; i < 8 && !ok; i++) begin
      cycle();
      n++;
      if (s_lk_ready) ok = 1'b1;
    end
    lk_valid = 1'b0;
    chk("lookup_accept_bound", ok, 1);
  endtask

  task automatic update_once(input logic [IDX_W-1:0] idx, input logic [ENTRY_W-1:0] d);
    up_valid = 1'b1;
    up_idx   = idx;
    up_data  = d;
    cycle();
    up_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $fatal(1, "FAIL global_timeout: observed=running expected=finished");
  end

  initial begin
    int          n;
    logic [63:0] r;
    logic [ENTRY_W-1:0] d7;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    lk_valid = 1'b0;
    lk_idx   = '0;
    up_valid = 1'b0;
    up_idx   = '0;
    up_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      if (i == DEPTH - 2) chk("init_done_before_256", init_done, 0);
    end
    chk("init_done_at_256", init_done, 1);

    update_once(8'd5, 39'h12_3456_789A);
    cycle();
    lookup_until(8'd5, n);
    cycle();
    chk("basic_rsp_valid", s_rsp_valid, 1);
    chk("basic_rsp_data", s_rsp_data, 39'h12_3456_789A);

    update_once(8'd20, 39'h0A_BCDE_F012);
    lk_valid = 1'b1;
    lk_idx   = 8'd30;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("age_lk_ready", s_lk_ready, (k == 3) ? 1'b0 : 1'b1);
      if (k == 3) chk("age_forced_write", s_ram_we, 1);
    end
    idle();
    cycle();

    r  = {$urandom(), $urandom()};
    d7 = r[ENTRY_W-1:0];
    update_once(8'd7, d7);
    lookup_until(8'd7, n);
    chk("same_idx_latency", n, BYP ? 1 : 2);
    cycle();
    chk("same_idx_rsp_data", s_rsp_data, d7);

    for (int i = 0; i < 600; i++) begin
      r        = {$urandom(), $urandom()};
      lk_valid = $urandom_range(0, 1) == 1;
      lk_idx   = IDX_W'($urandom_range(0, 15));
      up_valid = $urandom_range(0, 2) != 0;
      up_idx   = IDX_W'($urandom_range(0, 15));
      up_data  = r[ENTRY_W-1:0];
      cycle();
    end
    idle();
    repeat (6) cycle();

    update_once(8'd9, 39'h55_AA55_AA55);
    lk_valid = 1'b1;
    lk_idx   = 8'd100;
    flush    = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < DEPTH; i++) cycle();
    chk("flush_init_done", init_done, 1);
    lookup_until(8'd9, n);
    cycle();
    chk("flush_rsp_data", s_rsp_data, 0);
    repeat (4) cycle();
    lookup_until(8'd9, n);
    cycle();
    chk("flush_rsp_data_late", s_rsp_data, 0);

    update_once(8'd40, 39'h7F_0000_0001);
    lk_valid = 1'b1;
    lk_idx   = 8'd41;
    cycle();
    lk_valid = 1'b0;
    chk("inflight_rsp_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH + 4; i++) cycle();
    lookup_until(8'd40, n);
    cycle();
    chk("post_reset_rsp_data", s_rsp_data, 0);
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
